// File: rtl/knowles32_adder_if.sv
// Operand/result bundle for knowles32_adder.
// The ov signal exists only when KNOWLES32_OVF_EN is defined.
interface knowles32_adder_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic [31:0] s;
  logic        co;
`ifdef KNOWLES32_OVF_EN
  logic        ov;

  modport master (output a, output b, output ci, input s, input co, input ov);
  modport slave  (input a, input b, input ci, output s, output co, output ov);
`else
  modport master (output a, output b, output ci, input s, input co);
  modport slave  (input a, input b, input ci, output s, output co);
`endif
endinterface

// File: rtl/knowles32_adder.sv
// 32-bit Knowles [2,1,1,1,1] prefix adder with registered sum and carry-out.
// Define KNOWLES32_OVF_EN to add the registered signed-overflow output ov.
module knowles32_adder (
  input logic              clk,
  input logic              rst_n,
  knowles32_adder_if.slave bus
);

  logic [31:0] g0, p0, g1, p1, g2, p2, g3, p3, g4, p4, g5;
  logic [32:0] c;
  logic [31:0] sum;

  // One Kogge-Stone level: bit i absorbs the group ending at i-span.
  function automatic logic [63:0] ks_level(input logic [31:0] g, input logic [31:0] p,
                                           input int span);
    logic [31:0] go, po;
    go = g;
    po = p;
    for (int i = 0; i < 32; i++) begin
      if (i >= span) begin
        go[i] = g[i] | (p[i] & g[i-span]);
        po[i] = p[i] & p[i-span];
      end
    end
    return {go, po};
  endfunction

  // Carry-in is folded into bit 0 so the prefix G[i:0] is the carry into i+1.
  always_comb begin
    p0    = bus.a ^ bus.b;
    g0    = bus.a & bus.b;
    g0[0] = g0[0] | (p0[0] & bus.ci);
  end

  always_comb {g1, p1} = ks_level(g0, p0, 1);
  always_comb {g2, p2} = ks_level(g1, p1, 2);
  always_comb {g3, p3} = ks_level(g2, p2, 4);
  always_comb {g4, p4} = ks_level(g3, p3, 8);

  // Sparse last level: odd prefixes [j:0] each feed two upper-half cells.
  always_comb begin
    g5 = g4;
    for (int i = 16; i < 32; i++) begin
      g5[i] = g4[i] | (p4[i] & g4[(i-16) | 1]);
    end
  end

  always_comb begin
    c   = {g5, bus.ci};
    sum = p0 ^ c[31:0];
  end

  logic [31:0] s_q;
  logic        co_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      s_q  <= sum;
      co_q <= c[32];
    end
  end

  assign bus.s  = s_q;
  assign bus.co = co_q;

`ifdef KNOWLES32_OVF_EN
  logic ov_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
    end else begin
      ov_q <= c[31] ^ c[32];
    end
  end

  assign bus.ov = ov_q;
`endif

endmodule

// File: tb/tb_knowles32_adder.sv
// Self-checking bench for knowles32_adder against a 33-bit arithmetic reference.
module tb_knowles32_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  knowles32_adder_if bus ();

  knowles32_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {ov, co, s}; ov reads as 0 when the feature is compiled out.
  function automatic logic [33:0] observed();
`ifdef KNOWLES32_OVF_EN
    return {bus.ov, bus.co, bus.s};
`else
    return {1'b0, bus.co, bus.s};
`endif
  endfunction

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci);
    logic [32:0] total;
    logic        ov;
    total = {1'b0, a} + {1'b0, b} + {32'd0, ci};
`ifdef KNOWLES32_OVF_EN
    ov = (a[31] == b[31]) && (total[31] != a[31]);
`else
    ov = 1'b0;
`endif
    return {ov, total};
  endfunction

  task automatic chk(input string tag, input logic [33:0] exp);
    logic [33:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed={ov,co,s}=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a triple just after an edge, confirm the old result still holds
  // mid-cycle, then confirm the new result one edge later.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic [33:0] prev);
    bus.a  = a;
    bus.b  = b;
    bus.ci = ci;
    #3;
    chk({tag, "_hold"}, prev);
    @(posedge clk);
    #1;
    chk(tag, model(a, b, ci));
  endtask

  logic [33:0] prev;
  logic [31:0] ra, rb;
  logic        rc;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.a    = 32'hFFFF_FFFF;
    bus.b    = 32'h1;
    bus.ci   = 1'b1;

    // Outputs stay cleared across clock edges while reset is held.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", 34'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_release", model(32'hFFFF_FFFF, 32'h1, 1'b1));
    prev = model(32'hFFFF_FFFF, 32'h1, 1'b1);

    step("ripple_ci1", 32'hFFFF_FFFF, 32'h0, 1'b1, prev);
    prev = model(32'hFFFF_FFFF, 32'h0, 1'b1);
    chk("ripple_ci1_const", {1'b0, 1'b1, 32'h0000_0000});
    step("ripple_ci0", 32'hFFFF_FFFF, 32'h0, 1'b0, prev);
    prev = model(32'hFFFF_FFFF, 32'h0, 1'b0);
    chk("ripple_ci0_const", {1'b0, 1'b0, 32'hFFFF_FFFF});
    step("max_ops", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, prev);
    prev = model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("max_ops_const", {1'b0, 1'b1, 32'hFFFF_FFFF});
    step("pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, prev);
    prev = model(32'h7FFF_FFFF, 32'h1, 1'b0);
`ifdef KNOWLES32_OVF_EN
    chk("pos_ovf_const", {1'b1, 1'b0, 32'h8000_0000});
`else
    chk("pos_ovf_const", {1'b0, 1'b0, 32'h8000_0000});
`endif
    step("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, prev);
    prev = model(32'h8000_0000, 32'h8000_0000, 1'b0);
`ifdef KNOWLES32_OVF_EN
    chk("neg_ovf_const", {1'b1, 1'b1, 32'h0000_0000});
`else
    chk("neg_ovf_const", {1'b0, 1'b1, 32'h0000_0000});
`endif

    // Back-to-back distinct triples, including long carry chains per half.
    step("pipe0", 32'h0000_FFFF, 32'h0000_0001, 1'b0, prev);
    prev = model(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    step("pipe1", 32'h1234_5678, 32'h8765_4321, 1'b1, prev);
    prev = model(32'h1234_5678, 32'h8765_4321, 1'b1);
    step("pipe2", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, prev);
    prev = model(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    step("pipe3", 32'h7FFF_0000, 32'h0000_FFFF, 1'b1, prev);
    prev = model(32'h7FFF_0000, 32'h0000_FFFF, 1'b1);

    // Asynchronous reset mid-cycle clears without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 34'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    prev = model(32'h7FFF_0000, 32'h0000_FFFF, 1'b1);
    chk("reset_resume", prev);

    for (int i = 0; i < 4000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      case (i % 8)
        1: rb = ~ra;
        2: ra = ra | 32'h8000_0000;
        default: ;
      endcase
      step("random", ra, rb, rc, prev);
      prev = model(ra, rb, rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
